ins_fetch: RTL and testbench

- Instruction fetch responder at the far end of the program-counter address interface.
- Owns the instruction memory. Accepts a fetch request, latches the PC-supplied instruction address, reads the memory with configurable wait states, and presents the instruction word with a valid pulse.
- Pulses pc_inc back to the program counter so it can advance.
- Program memory is loaded through a write port while the block is idle, before start.

---
 rtl/ins_fetch.sv | 159 +++++++++++++++
 tb/tb_ins_fetch.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch.sv
// Instruction fetch responder: owns program memory, serves one fetch per request with READ_LAT wait states.
// Optional build macro ADDR_TRAP_EN adds an out-of-range address trap (addr_err output, PROG_END parameter).
module ins_fetch #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 8,
  parameter int                READ_LAT = 1,
  parameter logic [DATA_W-1:0] HALT_OP  = 8'hFF
`ifdef ADDR_TRAP_EN
  , parameter int              PROG_END = 511
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] ins_addr,
  input  logic              fetch_req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] ins_word,
  output logic              ins_valid,
  output logic              pc_inc,
  output logic              busy,
  output logic              halted,
`ifdef ADDR_TRAP_EN
  output logic              addr_err,
`endif
  output logic [2:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_ins_word;
  logic                r_start_q;
  logic                w_start_rise;
  logic                w_fetch;
  logic                w_capture;
  logic                w_mem_we;
  logic [DATA_W-1:0]   w_rd_word;
  logic [DATA_W-1:0]   w_cap_word;

  assign w_start_rise = start & ~r_start_q;
  assign w_mem_we     = rst_n & wr_en & (r_state == S_IDLE);
  assign w_rd_word    = r_mem[r_addr];

`ifdef ADDR_TRAP_EN
  localparam logic [ADDR_W-1:0] PROG_END_A = ADDR_W'(PROG_END);
  logic r_addr_err;
  logic w_oob;
  // An out-of-range fetch still spends its wait states but returns HALT_OP instead of memory.
  assign w_oob      = (r_addr > PROG_END_A);
  assign w_cap_word = w_oob ? HALT_OP : w_rd_word;
  assign addr_err   = r_addr_err;
`else
  assign w_cap_word = w_rd_word;
`endif

  assign ins_word  = r_ins_word;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake: fetch_req is accepted only in READY (no queuing, no back-pressure);
  // ins_valid/pc_inc are single-cycle pulses in DONE and the consumer must take them then.
  always_comb begin
    w_next_state = r_state;
    w_fetch      = 1'b0;
    w_capture    = 1'b0;
    ins_valid    = 1'b0;
    pc_inc       = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) w_next_state = S_READY;
      end
      S_READY: begin
        if (fetch_req) begin
          w_fetch      = 1'b1;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        ins_valid = 1'b1;
        if (r_ins_word == HALT_OP) begin
          w_next_state = S_HALT;
        end else begin
          pc_inc       = 1'b1;
          w_next_state = S_READY;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_cnt      <= '0;
      r_ins_word <= '0;
      r_start_q  <= 1'b0;
`ifdef ADDR_TRAP_EN
      r_addr_err <= 1'b0;
`endif
    end else begin
      r_start_q <= start;
      if (w_fetch) begin
        r_addr <= ins_addr;
        r_cnt  <= CNT_W'(READ_LAT - 1);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_ins_word <= w_cap_word;
`ifdef ADDR_TRAP_EN
        if (w_oob) r_addr_err <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Testbench for ins_fetch: transaction-level memory model, per-feature test tasks, expected-word queue.
`timescale 1ns/1ps
module tb_ins_fetch;

  localparam int         ADDR_W   = 9;
  localparam int         DATA_W   = 8;
  localparam int         READ_LAT = 3;
  localparam logic [7:0] HALT_OP  = 8'hFF;
`ifdef ADDR_TRAP_EN
  localparam int         PROG_END = 15;
`else
  localparam int         PROG_END = 511;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] ins_addr;
  logic              fetch_req;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] ins_word;
  logic              ins_valid;
  logic              pc_inc;
  logic              busy;
  logic              halted;
  logic [2:0]        dbg_state;
`ifdef ADDR_TRAP_EN
  logic              addr_err;
`endif

  ins_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .HALT_OP(HALT_OP)
`ifdef ADDR_TRAP_EN
    , .PROG_END(PROG_END)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ins_addr(ins_addr), .fetch_req(fetch_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ins_word(ins_word), .ins_valid(ins_valid), .pc_inc(pc_inc), .busy(busy), .halted(halted),
`ifdef ADDR_TRAP_EN
    .addr_err(addr_err),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: program memory as the bench believes it was loaded.
  logic [7:0] model_mem [512];
  int         fetchable_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  wire [11:0] w_outs = {ins_word, ins_valid, pc_inc, busy, halted};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    model_mem[a] = d;
    if (d != HALT_OP && !(a inside {fetchable_q})) fetchable_q.push_back(a);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic int pick_addr();
    return fetchable_q[$urandom_range(0, fetchable_q.size() - 1)];
  endfunction

  // One complete fetch from READY, checking every cycle from request to the return to READY/HALT.
  task automatic do_fetch(input int a, input bit hold);
    logic [7:0] exp_w;
    logic [7:0] got_w;
    logic       exp_halt, e_v, e_p;
    exp_w = (a > PROG_END) ? HALT_OP : model_mem[a];
    exp_halt = (exp_w == HALT_OP);
    exp_q.push_back(exp_w);
    ins_addr = ADDR_W'(a); fetch_req = 1'b1;
    tick();
    if (!hold) fetch_req = 1'b0;
    for (int k = 1; k <= READ_LAT + 1; k++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = ADDR_W'(a); wr_data = ~exp_w;
      if (hold) ins_addr = ADDR_W'($urandom_range(0, PROG_END));
      @(negedge clk);
      e_v = (k == READ_LAT + 1);
      e_p = e_v && !exp_halt;
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++; $display("FAIL fetch_busy addr=%0d cyc=%0d: got %b expected 1", a, k, busy);
      end
      n_cmp++;
      if (ins_valid !== e_v) begin
        n_err++; $display("FAIL fetch_valid addr=%0d cyc=%0d: got %b expected %b", a, k, ins_valid, e_v);
      end
      n_cmp++;
      if (pc_inc !== e_p) begin
        n_err++; $display("FAIL fetch_pc_inc addr=%0d cyc=%0d: got %b expected %b", a, k, pc_inc, e_p);
      end
      if (e_v) begin
        got_w = exp_q.pop_front();
        n_cmp++;
        if (ins_word !== got_w) begin
          n_err++; $display("FAIL fetch_word addr=%0d: got %h expected %h", a, ins_word, got_w);
        end
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (w_outs !== {exp_w, 1'b0, 1'b0, 1'b0, exp_halt}) begin
      n_err++; $display("FAIL fetch_after addr=%0d: got %h expected %h", a, w_outs, {exp_w, 3'b000, exp_halt});
    end
    fetch_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; fetch_req = 1'b0; wr_en = 1'b0;
    ins_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (3) begin
      start = 1'($urandom_range(0, 1)); fetch_req = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (w_outs !== 12'h000) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 000", w_outs);
    end
`ifdef ADDR_TRAP_EN
    n_cmp++;
    if (addr_err !== 1'b0) begin
      n_err++; $display("FAIL reset_addr_err: got %b expected 0", addr_err);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_start();
    load_word(0, 8'h12);
    load_word(1, 8'h34);
    load_word(5, 8'hFF);
    load_word(7, 8'h5A);
    repeat (30) load_word($urandom_range(8, PROG_END), 8'($urandom_range(0, 254)));
    // start edge coinciding with a write: the write must still land
    wr_en = 1'b1; wr_addr = ADDR_W'(2); wr_data = 8'h56; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    model_mem[2] = 8'h56; fetchable_q.push_back(2);
    @(negedge clk);
    n_cmp++;
    if (w_outs !== 12'h000) begin
      n_err++; $display("FAIL ready_outputs: got %h expected 000", w_outs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_fetch(0, 1'b0);
    do_fetch(1, 1'b0);
    do_fetch(2, 1'b0);
    do_fetch(7, 1'b1);
  endtask

  task automatic test_back_to_back();
    int cyc, got, exp_cyc, a;
    logic [7:0] w;
    a = pick_addr();
    exp_q.push_back(model_mem[a]);
    ins_addr = ADDR_W'(a); fetch_req = 1'b1;
    tick();
    cyc = 1; got = 0; exp_cyc = READ_LAT + 1;
    while (got < 6 && cyc < 200) begin
      @(negedge clk);
      if (ins_valid === 1'b1) begin
        w = exp_q.pop_front();
        n_cmp++;
        if (ins_word !== w) begin
          n_err++; $display("FAIL b2b_word #%0d: got %h expected %h", got, ins_word, w);
        end
        n_cmp++;
        if (cyc != exp_cyc) begin
          n_err++; $display("FAIL b2b_timing #%0d: valid at cycle %0d expected %0d", got, cyc, exp_cyc);
        end
        exp_cyc = cyc + READ_LAT + 2;
        got++;
        if (got < 6) begin
          a = pick_addr();
          exp_q.push_back(model_mem[a]);
          ins_addr = ADDR_W'(a);
        end else begin
          fetch_req = 1'b0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    fetch_req = 1'b0;
    n_cmp++;
    if (got != 6) begin
      n_err++; $display("FAIL b2b_timeout: got %0d instructions expected 6", got);
    end
  endtask

  task automatic test_random();
    repeat (16) do_fetch(pick_addr(), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_ignore_write();
    wr_en = 1'b1; wr_addr = ADDR_W'(7); wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    do_fetch(7, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    ins_addr = '0; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (w_outs !== 12'h000) begin
        n_err++; $display("FAIL abort_outputs cyc=%0d: got %h expected 000", k, w_outs);
      end
      rst_n = 1'b1;
    end
    @(posedge clk); #1;
    fetch_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++; $display("FAIL idle_ignores_fetch cyc=%0d: got busy=%b expected 0", k, busy);
      end
    end
    fetch_req = 1'b0;
    @(posedge clk); #1;
    do_start();
    do_fetch(1, 1'b0);
  endtask

  task automatic test_halt();
    do_fetch(5, 1'b0);
    for (int k = 0; k < 10; k++) begin
      start = 1'($urandom_range(0, 1)); fetch_req = 1'($urandom_range(0, 1));
      wr_en = 1'($urandom_range(0, 1)); wr_addr = '0; wr_data = ~model_mem[0];
      ins_addr = ADDR_W'(pick_addr());
      @(negedge clk);
      n_cmp++;
      if (w_outs !== {HALT_OP, 4'b0001}) begin
        n_err++; $display("FAIL halt_hold cyc=%0d: got %h expected %h state=%0d", k, w_outs, {HALT_OP, 4'b0001}, dbg_state);
      end
      @(posedge clk); #1;
    end
    start = 1'b0; fetch_req = 1'b0; wr_en = 1'b0;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (w_outs !== 12'h000) begin
      n_err++; $display("FAIL halt_reset: got %h expected 000", w_outs);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    do_fetch(0, 1'b0);
  endtask

`ifdef ADDR_TRAP_EN
  task automatic test_addr_trap();
    n_cmp++;
    if (addr_err !== 1'b0) begin
      n_err++; $display("FAIL trap_clear_before: got %b expected 0", addr_err);
    end
    do_fetch(PROG_END + 1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (addr_err !== 1'b1 || halted !== 1'b1) begin
        n_err++; $display("FAIL trap_sticky: got addr_err=%b halted=%b expected 1 1", addr_err, halted);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (addr_err !== 1'b0) begin
      n_err++; $display("FAIL trap_reset: got %b expected 0", addr_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_start();
    test_basic();
    test_back_to_back();
    test_random();
    test_ignore_write();
    test_reset_mid_wait();
    test_halt();
`ifdef ADDR_TRAP_EN
    test_addr_trap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
